bits_frame_sync: RTL and testbench

// - Consumes the serial demodulated bit stream (1 bit + valid per clk) produced by the bit flattening stage.
// - Searches for a sync word, resolving the 180-degree PSK phase ambiguity by also matching its inverse.
// - Once locked, packs a fixed-length payload into bytes and emits each byte with a valid strobe.
// - Flags the last byte of every frame for the downstream byte sink.

---
 rtl/bits_frame_sync.sv | 145 ++++++++++++++
 tb/tb_bits_frame_sync.sv | 369 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/bits_frame_sync.sv
// Frame synchronizer: finds the sync word (or its inverse) in a serial bit stream,
// then packs a fixed-length payload into bytes with valid/last strobes.
module bits_frame_sync #(
    parameter logic [31:0] SYNC_WORD     = 32'h1ACFFC1D,
    parameter int          SYNC_LEN      = 32,
    parameter int          MAX_ERR       = 0,
    parameter int          ALLOW_INV     = 1,
    parameter int          PAYLOAD_BYTES = 16
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        I,
    input  logic        I_vld,
    output logic [7:0]  O,
    output logic        O_vld,
    output logic        O_last,
    output logic        locked,
    output logic        inverted,
    output logic [15:0] frame_cnt
);

    localparam int CW = $clog2(SYNC_LEN + 1);
    localparam int BW = (PAYLOAD_BYTES > 1) ? $clog2(PAYLOAD_BYTES) : 1;
    localparam logic [SYNC_LEN-1:0] SW     = SYNC_WORD[SYNC_LEN-1:0];
    localparam logic [CW-1:0]       LEN_C  = CW'(SYNC_LEN);
    localparam logic [CW-1:0]       ERR_C  = CW'(MAX_ERR);
    localparam logic [BW-1:0]       LAST_C = BW'(PAYLOAD_BYTES - 1);

    typedef enum logic {SEARCH = 1'b0, PAYLOAD = 1'b1} state_t;

    state_t              state_q, state_d;
    logic [SYNC_LEN-1:0] sr_q, sr_d;
    logic [CW-1:0]       fill_q, fill_d;
    logic [2:0]          bit_cnt_q, bit_cnt_d;
    logic [BW-1:0]       byte_cnt_q, byte_cnt_d;
    logic [7:0]          byte_q, byte_d;
    logic [7:0]          o_q, o_d;
    logic                o_vld_q, o_vld_d;
    logic                o_last_q, o_last_d;
    logic                inverted_q, inverted_d;
    logic [15:0]         frame_cnt_q, frame_cnt_d;

    logic [SYNC_LEN-1:0] cand;
    logic [CW-1:0]       d0, d1;
    logic                filled, hit_n, hit_i;
    logic [7:0]          byte_nx;

    always_comb begin
        cand = {sr_q[SYNC_LEN-2:0], I};
        d0   = '0;
        for (int i = 0; i < SYNC_LEN; i++) begin
            d0 = d0 + CW'(cand[i] ^ SW[i]);
        end
        d1      = LEN_C - d0;
        // The incoming bit counts toward the window, so one short of full is enough.
        filled  = (fill_q >= LEN_C - CW'(1));
        hit_n   = filled && (d0 <= ERR_C);
        hit_i   = filled && (ALLOW_INV != 0) && (d1 <= ERR_C);
        byte_nx = {byte_q[6:0], I ^ inverted_q};

        state_d     = state_q;
        sr_d        = sr_q;
        fill_d      = fill_q;
        bit_cnt_d   = bit_cnt_q;
        byte_cnt_d  = byte_cnt_q;
        byte_d      = byte_q;
        o_d         = o_q;
        o_vld_d     = 1'b0;
        o_last_d    = 1'b0;
        inverted_d  = inverted_q;
        frame_cnt_d = frame_cnt_q;

        case (state_q)
            SEARCH: begin
                if (I_vld) begin
                    sr_d = cand;
                    if (fill_q != LEN_C) fill_d = fill_q + CW'(1);
                    if (hit_n || hit_i) begin
                        state_d    = PAYLOAD;
                        inverted_d = !hit_n;
                        bit_cnt_d  = '0;
                        byte_cnt_d = '0;
                    end
                end
            end
            PAYLOAD: begin
                if (I_vld) begin
                    byte_d    = byte_nx;
                    bit_cnt_d = bit_cnt_q + 3'd1;
                    if (bit_cnt_q == 3'd7) begin
                        o_d     = byte_nx;
                        o_vld_d = 1'b1;
                        if (byte_cnt_q == LAST_C) begin
                            // Next sync must arrive entirely after the payload.
                            o_last_d    = 1'b1;
                            frame_cnt_d = frame_cnt_q + 16'd1;
                            state_d     = SEARCH;
                            sr_d        = '0;
                            fill_d      = '0;
                        end else begin
                            byte_cnt_d = byte_cnt_q + BW'(1);
                        end
                    end
                end
            end
            default: state_d = SEARCH;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= SEARCH;
            sr_q        <= '0;
            fill_q      <= '0;
            bit_cnt_q   <= '0;
            byte_cnt_q  <= '0;
            byte_q      <= '0;
            o_q         <= '0;
            o_vld_q     <= 1'b0;
            o_last_q    <= 1'b0;
            inverted_q  <= 1'b0;
            frame_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            sr_q        <= sr_d;
            fill_q      <= fill_d;
            bit_cnt_q   <= bit_cnt_d;
            byte_cnt_q  <= byte_cnt_d;
            byte_q      <= byte_d;
            o_q         <= o_d;
            o_vld_q     <= o_vld_d;
            o_last_q    <= o_last_d;
            inverted_q  <= inverted_d;
            frame_cnt_q <= frame_cnt_d;
        end
    end

    assign O         = o_q;
    assign O_vld     = o_vld_q;
    assign O_last    = o_last_q;
    assign locked    = (state_q == PAYLOAD);
    assign inverted  = inverted_q;
    assign frame_cnt = frame_cnt_q;

endmodule

// File: tb/tb_bits_frame_sync.sv
// Directed bench for bits_frame_sync: main instance plus no-inversion and
// MAX_ERR=1 variants sharing the same input stream.
module tb_bits_frame_sync;

    localparam logic [31:0] SYNC = 32'h1ACFFC1D;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic I = 1'b0;
    logic I_vld = 1'b0;

    logic [7:0]  O, n_o, e_o;
    logic        O_vld, O_last, locked, inverted;
    logic        n_vld, n_last, n_locked, n_inv;
    logic        e_vld, e_last, e_locked, e_inv;
    logic [15:0] frame_cnt, n_fc, e_fc;

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    logic [7:0] q_byte[$];
    logic       q_last[$];
    int         q_cyc[$];
    logic [7:0] e_byte[$];
    logic       e_lastq[$];
    int         n_vld_cnt = 0;
    int         n_lock_cnt = 0;

    bits_frame_sync #(.SYNC_WORD(SYNC), .SYNC_LEN(32), .MAX_ERR(0), .ALLOW_INV(1), .PAYLOAD_BYTES(2)) dut (
        .clk(clk), .rst_n(rst_n), .I(I), .I_vld(I_vld), .O(O), .O_vld(O_vld), .O_last(O_last),
        .locked(locked), .inverted(inverted), .frame_cnt(frame_cnt));

    bits_frame_sync #(.SYNC_WORD(SYNC), .SYNC_LEN(32), .MAX_ERR(0), .ALLOW_INV(0), .PAYLOAD_BYTES(2)) dut_ni (
        .clk(clk), .rst_n(rst_n), .I(I), .I_vld(I_vld), .O(n_o), .O_vld(n_vld), .O_last(n_last),
        .locked(n_locked), .inverted(n_inv), .frame_cnt(n_fc));

    bits_frame_sync #(.SYNC_WORD(SYNC), .SYNC_LEN(32), .MAX_ERR(1), .ALLOW_INV(1), .PAYLOAD_BYTES(2)) dut_e1 (
        .clk(clk), .rst_n(rst_n), .I(I), .I_vld(I_vld), .O(e_o), .O_vld(e_vld), .O_last(e_last),
        .locked(e_locked), .inverted(e_inv), .frame_cnt(e_fc));

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (O_vld) begin
            q_byte.push_back(O);
            q_last.push_back(O_last);
            q_cyc.push_back(cyc);
        end
        if (e_vld) begin
            e_byte.push_back(e_o);
            e_lastq.push_back(e_last);
        end
        if (n_vld) n_vld_cnt++;
        if (n_locked) n_lock_cnt++;
    end

    task automatic send_word(input logic [31:0] w, input int n, input bit gaps);
        int g;
        for (int i = n - 1; i >= 0; i--) begin
            if (gaps) begin
                g = $urandom_range(0, 2);
                repeat (g) begin
                    @(posedge clk); #1;
                    I_vld = 1'b0;
                end
            end
            @(posedge clk); #1;
            I = w[i];
            I_vld = 1'b1;
        end
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk); #1;
            I_vld = 1'b0;
        end
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        I_vld = 1'b0;
        I = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        I_vld = 1'b0;
        #2;
        checks++;
        if ({O, O_vld, O_last, locked, frame_cnt} !== 27'd0) begin
            errors++;
            $display("FAIL reset_outputs: got O=%h vld=%b last=%b locked=%b fc=%0d, expected all zero",
                     O, O_vld, O_last, locked, frame_cnt);
        end
        checks++;
        if (inverted !== 1'b0) begin
            errors++;
            $display("FAIL reset_inverted: got %b expected 0", inverted);
        end
        @(posedge clk); #1;
        rst_n = 1'b1;
    endtask

    task automatic test_basic();
        int base;
        do_reset();
        base = q_byte.size();
        send_word(SYNC, 32, 1'b0);
        send_word(32'h0000A55A, 16, 1'b0);
        checks++;
        if (locked !== 1'b1) begin
            errors++;
            $display("FAIL basic_locked: got %b expected 1", locked);
        end
        idle(1);
        checks++;
        if ({O_vld, O_last, O} !== {1'b1, 1'b1, 8'h5A}) begin
            errors++;
            $display("FAIL basic_last_latency: got vld=%b last=%b O=%h expected vld=1 last=1 O=5a",
                     O_vld, O_last, O);
        end
        checks++;
        if (frame_cnt !== 16'd1 || locked !== 1'b0 || inverted !== 1'b0) begin
            errors++;
            $display("FAIL basic_status: got fc=%0d locked=%b inv=%b expected fc=1 locked=0 inv=0",
                     frame_cnt, locked, inverted);
        end
        idle(1);
        checks++;
        if (O_vld !== 1'b0 || O !== 8'h5A) begin
            errors++;
            $display("FAIL basic_hold: got vld=%b O=%h expected vld=0 O=5a", O_vld, O);
        end
        checks++;
        if (q_byte.size() - base != 2) begin
            errors++;
            $display("FAIL basic_count: got %0d bytes expected 2", q_byte.size() - base);
        end else begin
            checks++;
            if (q_byte[base] !== 8'hA5 || q_last[base] !== 1'b0) begin
                errors++;
                $display("FAIL basic_byte0: got %h last=%b expected a5 last=0", q_byte[base], q_last[base]);
            end
            checks++;
            if (q_cyc[base+1] - q_cyc[base] != 8) begin
                errors++;
                $display("FAIL basic_spacing: got %0d expected 8", q_cyc[base+1] - q_cyc[base]);
            end
        end
    endtask

    task automatic test_inverted();
        int base, nv, nl;
        do_reset();
        base = q_byte.size();
        nv = n_vld_cnt;
        nl = n_lock_cnt;
        send_word(~SYNC, 32, 1'b0);
        send_word(32'h00005AA5, 16, 1'b0);
        idle(2);
        checks++;
        if (q_byte.size() - base != 2) begin
            errors++;
            $display("FAIL inv_count: got %0d bytes expected 2", q_byte.size() - base);
        end else begin
            checks++;
            if (q_byte[base] !== 8'hA5 || q_byte[base+1] !== 8'h5A || q_last[base+1] !== 1'b1) begin
                errors++;
                $display("FAIL inv_bytes: got %h %h last=%b expected a5 5a last=1",
                         q_byte[base], q_byte[base+1], q_last[base+1]);
            end
        end
        checks++;
        if (inverted !== 1'b1 || frame_cnt !== 16'd1) begin
            errors++;
            $display("FAIL inv_status: got inv=%b fc=%0d expected inv=1 fc=1", inverted, frame_cnt);
        end
        checks++;
        if (n_vld_cnt != nv || n_lock_cnt != nl || n_fc !== 16'd0) begin
            errors++;
            $display("FAIL noinv_lock: got vld=%0d lockcyc=%0d fc=%0d expected 0 0 0",
                     n_vld_cnt - nv, n_lock_cnt - nl, n_fc);
        end
    endtask

    task automatic test_max_err();
        int base, ebase;
        do_reset();
        base = q_byte.size();
        ebase = e_byte.size();
        send_word(SYNC ^ 32'h1, 32, 1'b0);
        send_word(32'h00003C96, 16, 1'b0);
        idle(2);
        checks++;
        if (q_byte.size() != base || frame_cnt !== 16'd0) begin
            errors++;
            $display("FAIL err0_nolock: got %0d bytes fc=%0d expected 0 bytes fc=0",
                     q_byte.size() - base, frame_cnt);
        end
        checks++;
        if (e_byte.size() - ebase != 2) begin
            errors++;
            $display("FAIL err1_count: got %0d bytes expected 2", e_byte.size() - ebase);
        end else begin
            checks++;
            if (e_byte[ebase] !== 8'h3C || e_byte[ebase+1] !== 8'h96 || e_lastq[ebase+1] !== 1'b1) begin
                errors++;
                $display("FAIL err1_bytes: got %h %h last=%b expected 3c 96 last=1",
                         e_byte[ebase], e_byte[ebase+1], e_lastq[ebase+1]);
            end
        end
        checks++;
        if (e_fc !== 16'd1 || e_inv !== 1'b0) begin
            errors++;
            $display("FAIL err1_status: got fc=%0d inv=%b expected fc=1 inv=0", e_fc, e_inv);
        end
    endtask

    task automatic test_gaps();
        int base, mind;
        do_reset();
        base = q_byte.size();
        send_word(SYNC, 32, 1'b1);
        send_word(32'h0000A55A, 16, 1'b1);
        idle(2);
        checks++;
        if (q_byte.size() - base != 2) begin
            errors++;
            $display("FAIL gap_count: got %0d bytes expected 2", q_byte.size() - base);
        end else begin
            checks++;
            if (q_byte[base] !== 8'hA5 || q_byte[base+1] !== 8'h5A || q_last[base+1] !== 1'b1) begin
                errors++;
                $display("FAIL gap_bytes: got %h %h last=%b expected a5 5a last=1",
                         q_byte[base], q_byte[base+1], q_last[base+1]);
            end
            mind = q_cyc[base+1] - q_cyc[base];
            checks++;
            if (mind < 8) begin
                errors++;
                $display("FAIL gap_spacing: got %0d expected >= 8", mind);
            end
        end
        checks++;
        if (frame_cnt !== 16'd1) begin
            errors++;
            $display("FAIL gap_fc: got %0d expected 1", frame_cnt);
        end
    endtask

    task automatic test_back_to_back();
        int base;
        logic [7:0] exp_b [6];
        logic       exp_l [6];
        exp_b = '{8'h1A, 8'hCF, 8'h5A, 8'h5A, 8'h00, 8'hFF};
        exp_l = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
        do_reset();
        base = q_byte.size();
        send_word(SYNC, 32, 1'b0);
        send_word(32'h00001ACF, 16, 1'b0);
        idle(1);
        checks++;
        if (frame_cnt !== 16'd1) begin
            errors++;
            $display("FAIL b2b_fc1: got %0d expected 1", frame_cnt);
        end
        send_word(32'h0000FC1D, 16, 1'b0);
        send_word(SYNC, 32, 1'b0);
        send_word(32'h00005A5A, 16, 1'b0);
        idle(1);
        checks++;
        if (frame_cnt !== 16'd2) begin
            errors++;
            $display("FAIL b2b_fc2: got %0d expected 2", frame_cnt);
        end
        send_word(SYNC, 32, 1'b0);
        send_word(32'h000000FF, 16, 1'b0);
        idle(1);
        checks++;
        if (frame_cnt !== 16'd3) begin
            errors++;
            $display("FAIL b2b_fc3: got %0d expected 3", frame_cnt);
        end
        idle(1);
        checks++;
        if (q_byte.size() - base != 6) begin
            errors++;
            $display("FAIL b2b_count: got %0d bytes expected 6", q_byte.size() - base);
        end else begin
            for (int k = 0; k < 6; k++) begin
                checks++;
                if (q_byte[base+k] !== exp_b[k] || q_last[base+k] !== exp_l[k]) begin
                    errors++;
                    $display("FAIL b2b_byte%0d: got %h last=%b expected %h last=%b",
                             k, q_byte[base+k], q_last[base+k], exp_b[k], exp_l[k]);
                end
            end
        end
    endtask

    task automatic test_mid_reset();
        int base;
        base = q_byte.size();
        send_word(SYNC, 32, 1'b0);
        send_word(32'h00000016, 5, 1'b0);
        idle(1);
        checks++;
        if (locked !== 1'b1) begin
            errors++;
            $display("FAIL midrst_prelock: got %b expected 1", locked);
        end
        rst_n = 1'b0;
        #2;
        checks++;
        if (locked !== 1'b0 || frame_cnt !== 16'd0 || O_vld !== 1'b0) begin
            errors++;
            $display("FAIL midrst_state: got locked=%b fc=%0d vld=%b expected 0 0 0",
                     locked, frame_cnt, O_vld);
        end
        @(posedge clk); #1;
        rst_n = 1'b1;
        idle(10);
        checks++;
        if (q_byte.size() != base) begin
            errors++;
            $display("FAIL midrst_novld: got %0d bytes expected 0", q_byte.size() - base);
        end
        send_word(SYNC, 32, 1'b0);
        send_word(32'h0000A55A, 16, 1'b0);
        idle(2);
        checks++;
        if (q_byte.size() - base != 2) begin
            errors++;
            $display("FAIL midrst_count: got %0d bytes expected 2", q_byte.size() - base);
        end else begin
            checks++;
            if (q_byte[base] !== 8'hA5 || q_byte[base+1] !== 8'h5A) begin
                errors++;
                $display("FAIL midrst_bytes: got %h %h expected a5 5a", q_byte[base], q_byte[base+1]);
            end
        end
        checks++;
        if (frame_cnt !== 16'd1) begin
            errors++;
            $display("FAIL midrst_fc: got %0d expected 1", frame_cnt);
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_inverted();
        test_reset();
        test_max_err();
        test_gaps();
        test_back_to_back();
        test_mid_reset();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
